// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode and execute, feeding the ALU.
// Every accepted instruction is decoded into a 4-bit ALU code, an operand-1
// source (RS1/PC/ZERO), an operand-2 source (RS2/IMM/FOUR) and a register
// write enable. The decoded fields are then registered. The ALU operands are
// built combinationally from the registered slot, and MEM/WB bypass is applied
// to register-sourced operands.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall, flush                  hazard control (flush beats stall)
//   in_valid, in_pc, in_rs*_data, in_imm, in_rs*_addr, in_rd_addr,
//   in_opcode, in_funct3, in_funct7_5   decode-side instruction
//   mem_fwd_en/rd/data            EX/MEM result bypass
//   wb_fwd_en/rd/data             writeback bypass (same cycle as RF write)
//   ex_valid, alu_op, operand1, operand2, ex_rd_addr, ex_reg_write, ex_pc
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            ex_valid,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Encoding 0 of each select yields a zero operand when the rest of the
    // slot is zero, so a reset or bubble slot drives 0 with no extra gating.
    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS1  = 2'd1,
        OP1_PC   = 2'd2
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_IMM  = 2'd0,
        OP2_RS2  = 2'd1,
        OP2_FOUR = 2'd2
    } op2_sel_t;

    // ---------------- decode (combinational on inputs) ----------------
    logic [3:0] dec_alu_op;
    op1_sel_t   dec_op1_sel;
    op2_sel_t   dec_op2_sel;
    logic       dec_reg_write;

    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_op1_sel   = OP1_RS1;
        dec_op2_sel   = OP2_RS2;
        dec_reg_write = 1'b0;
        case (in_opcode)
            OPC_OP: begin
                dec_alu_op    = {in_funct7_5, in_funct3};
                dec_reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                // funct7[5] only distinguishes SRAI from SRLI; for other
                // immediates that bit is part of the immediate value.
                dec_alu_op    = {(in_funct3 == 3'b101) ? in_funct7_5 : 1'b0, in_funct3};
                dec_op2_sel   = OP2_IMM;
                dec_reg_write = 1'b1;
            end
            OPC_LUI: begin
                dec_op1_sel   = OP1_ZERO;
                dec_op2_sel   = OP2_IMM;
                dec_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op1_sel   = OP1_PC;
                dec_op2_sel   = OP2_IMM;
                dec_reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec_op2_sel   = OP2_IMM;
                dec_reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec_op2_sel   = OP2_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU computes the link value pc + 4.
                dec_op1_sel   = OP1_PC;
                dec_op2_sel   = OP2_FOUR;
                dec_reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec_alu_op    = ALU_SUB;
            end
            default: begin
            end
        endcase
        if (in_rd_addr == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    // ---------------- pipeline registers ----------------
    logic            valid_reg;
    logic [3:0]      alu_op_reg;
    op1_sel_t        op1_sel_reg;
    op2_sel_t        op2_sel_reg;
    logic            reg_write_reg;
    logic [4:0]      rd_addr_reg;
    logic [4:0]      rs1_addr_reg;
    logic [4:0]      rs2_addr_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;
    logic [XLEN-1:0] imm_reg;

    logic wb_hits_rs1;
    logic wb_hits_rs2;

    assign wb_hits_rs1 = wb_fwd_en && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == rs1_addr_reg);
    assign wb_hits_rs2 = wb_fwd_en && (wb_fwd_rd != 5'd0) && (wb_fwd_rd == rs2_addr_reg);

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            valid_reg     <= 1'b0;
            alu_op_reg    <= ALU_ADD;
            op1_sel_reg   <= OP1_ZERO;
            op2_sel_reg   <= OP2_IMM;
            reg_write_reg <= 1'b0;
            rd_addr_reg   <= 5'd0;
            rs1_addr_reg  <= 5'd0;
            rs2_addr_reg  <= 5'd0;
            pc_reg        <= '0;
            rs1_data_reg  <= '0;
            rs2_data_reg  <= '0;
            imm_reg       <= '0;
        end else if (stall) begin
            // Held slot: capture a retiring writeback so the operand stays
            // correct once that producer leaves the bypass network.
            if (wb_hits_rs1) begin
                rs1_data_reg <= wb_fwd_data;
            end
            if (wb_hits_rs2) begin
                rs2_data_reg <= wb_fwd_data;
            end
        end else begin
            valid_reg     <= 1'b1;
            alu_op_reg    <= dec_alu_op;
            op1_sel_reg   <= dec_op1_sel;
            op2_sel_reg   <= dec_op2_sel;
            reg_write_reg <= dec_reg_write;
            rd_addr_reg   <= in_rd_addr;
            rs1_addr_reg  <= in_rs1_addr;
            rs2_addr_reg  <= in_rs2_addr;
            pc_reg        <= in_pc;
            rs1_data_reg  <= in_rs1_data;
            rs2_data_reg  <= in_rs2_data;
            imm_reg       <= in_imm;
        end
    end

    // ---------------- bypass and operand select ----------------
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    always_comb begin
        rs1_fwd = rs1_data_reg;
        if (mem_fwd_en && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs1_addr_reg)) begin
            rs1_fwd = mem_fwd_data;
        end else if (wb_hits_rs1) begin
            rs1_fwd = wb_fwd_data;
        end

        rs2_fwd = rs2_data_reg;
        if (mem_fwd_en && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs2_addr_reg)) begin
            rs2_fwd = mem_fwd_data;
        end else if (wb_hits_rs2) begin
            rs2_fwd = wb_fwd_data;
        end
    end

    always_comb begin
        operand1 = '0;
        case (op1_sel_reg)
            OP1_RS1: operand1 = rs1_fwd;
            OP1_PC:  operand1 = pc_reg;
            default: operand1 = '0;
        endcase

        operand2 = '0;
        case (op2_sel_reg)
            OP2_RS2:  operand2 = rs2_fwd;
            OP2_FOUR: operand2 = XLEN'(4);
            default:  operand2 = imm_reg;
        endcase
    end

    assign ex_valid     = valid_reg;
    assign alu_op       = alu_op_reg;
    assign ex_rd_addr   = rd_addr_reg;
    assign ex_reg_write = reg_write_reg;
    assign ex_pc        = pc_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. A behavioural model holds the expected
// contents of the execute slot (what each operand *means*: register, pc,
// constant) and a compare process checks every DUT output against it on each
// falling edge. Directed steps add literal, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_reg_write;
    logic [3:0]  alu_op;
    logic [31:0] operand1, operand2, ex_pc;
    logic [4:0]  ex_rd_addr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_en(wb_fwd_en),
        .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .alu_op(alu_op), .operand1(operand1),
        .operand2(operand2), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
    );

    // ---------------- behavioural model ----------------
    // Operand meaning: 'r' register value, 'p' pc, 'z' zero, 'i' imm, 'f' four.
    bit          m_valid = 0;
    logic [3:0]  m_op    = 0;
    byte         m_src1  = "z";
    byte         m_src2  = "z";
    bit          m_rw    = 0;
    logic [4:0]  m_rd = 0, m_rs1 = 0, m_rs2 = 0;
    logic [31:0] m_pc = 0, m_r1 = 0, m_r2 = 0, m_imm = 0;

    function automatic logic [31:0] reg_value(input logic [4:0] a, input logic [31:0] held);
        if (mem_fwd_en && mem_fwd_rd != 0 && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_rd != 0 && wb_fwd_rd == a)    return wb_fwd_data;
        return held;
    endfunction

    always @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            m_valid = 0; m_op = 0; m_src1 = "z"; m_src2 = "z"; m_rw = 0;
            m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
        end else if (stall) begin
            if (wb_fwd_en && wb_fwd_rd != 0 && wb_fwd_rd == m_rs1) m_r1 = wb_fwd_data;
            if (wb_fwd_en && wb_fwd_rd != 0 && wb_fwd_rd == m_rs2) m_r2 = wb_fwd_data;
        end else begin
            m_valid = 1; m_rd = in_rd_addr; m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr;
            m_pc = in_pc; m_r1 = in_rs1_data; m_r2 = in_rs2_data; m_imm = in_imm;
            m_op = 0; m_src1 = "r"; m_src2 = "r"; m_rw = 0;
            case (in_opcode)
                7'b0110011: begin m_op = {in_funct7_5, in_funct3}; m_rw = 1; end
                7'b0010011: begin
                    m_op = {(in_funct3 == 3'd5) && in_funct7_5, in_funct3};
                    m_src2 = "i"; m_rw = 1;
                end
                7'b0110111: begin m_src1 = "z"; m_src2 = "i"; m_rw = 1; end
                7'b0010111: begin m_src1 = "p"; m_src2 = "i"; m_rw = 1; end
                7'b0000011: begin m_src2 = "i"; m_rw = 1; end
                7'b0100011: begin m_src2 = "i"; end
                7'b1101111, 7'b1100111: begin m_src1 = "p"; m_src2 = "f"; m_rw = 1; end
                7'b1100011: m_op = 4'b1000;
                default: ;
            endcase
            if (in_rd_addr == 0) m_rw = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs versus the model.
    always @(negedge clk) begin
        logic [31:0] e1, e2;
        e1 = (m_src1 == "r") ? reg_value(m_rs1, m_r1) : (m_src1 == "p") ? m_pc : 32'd0;
        e2 = (m_src2 == "r") ? reg_value(m_rs2, m_r2) : (m_src2 == "i") ? m_imm :
             (m_src2 == "f") ? 32'd4 : 32'd0;
        chk("model_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("model_alu_op", {28'd0, alu_op}, {28'd0, m_op});
        chk("model_operand1", operand1, e1);
        chk("model_operand2", operand2, e2);
        chk("model_rd", {27'd0, ex_rd_addr}, {27'd0, m_rd});
        chk("model_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
        chk("model_pc", ex_pc, m_pc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_fwd_en = 0;  wb_fwd_rd = 0;  wb_fwd_data = 0;
    endtask

    task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
        in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
        in_rd_addr = rd; in_imm = imm; in_pc = pc;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
        chk({tag, "_op1"}, operand1, 32'd0);
        chk({tag, "_op2"}, operand2, 32'd0);
        chk({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
        chk({tag, "_rd"}, {27'd0, ex_rd_addr}, 32'd0);
        chk({tag, "_pc"}, ex_pc, 32'd0);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_fwd();
        instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'h9, 5'd2, 32'h9, 5'd3, 32'h9, 32'h9);
        tick(); tick();
        $display("txn reset");
        chk_bubble("reset");
        rst = 0;

        instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 32'h40);
        tick();
        $display("txn OP ADD");
        chk("add_alu_op", {28'd0, alu_op}, 32'h0);
        chk("add_op1", operand1, 32'd5);
        chk("add_op2", operand2, 32'd7);
        chk("add_rw", {31'd0, ex_reg_write}, 32'd1);
        chk("add_rd", {27'd0, ex_rd_addr}, 32'd3);

        instr(7'b0010011, 3'b101, 1'b1, 5'd1, 32'h80, 5'd0, 32'd0, 5'd3, 32'd4, 32'h44);
        tick();
        $display("txn OP-IMM SRAI");
        chk("srai_alu_op", {28'd0, alu_op}, 32'hD);
        chk("srai_op2", operand2, 32'd4);

        instr(7'b0010011, 3'b000, 1'b1, 5'd1, 32'h80, 5'd0, 32'd0, 5'd3, 32'd4, 32'h48);
        tick();
        $display("txn OP-IMM ADDI f7=1");
        chk("addi_alu_op", {28'd0, alu_op}, 32'h0);

        instr(7'b0110011, 3'b000, 1'b1, 5'd1, 32'd9, 5'd2, 32'd3, 5'd3, 32'd0, 32'h4C);
        tick();
        $display("txn OP SUB");
        chk("sub_alu_op", {28'd0, alu_op}, 32'h8);

        instr(7'b0110011, 3'd0, 1'b0, 5'd5, 32'h11, 5'd0, 32'h22, 5'd7, 32'd0, 32'h50);
        tick();
        in_valid = 0;
        mem_fwd_en = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAAAA;
        wb_fwd_en = 1;  wb_fwd_rd = 5'd5;  wb_fwd_data = 32'hBBBB;
        #1;
        $display("txn bypass MEM+WB");
        chk("byp_mem_wins", operand1, 32'hAAAA);
        mem_fwd_en = 0;
        #1;
        $display("txn bypass WB");
        chk("byp_wb", operand1, 32'hBBBB);
        clear_fwd();
        mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hCCCC;
        #1;
        $display("txn bypass rd0");
        chk("byp_rd0_op2", operand2, 32'h22);
        chk("byp_none_op1", operand1, 32'h11);
        clear_fwd();
        tick();
        $display("txn idle bubble");
        chk_bubble("idle");

        instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd1, 5'd9, 32'h55, 5'd4, 32'd0, 32'h60);
        tick();
        stall = 1;
        instr(7'b0110011, 3'd7, 1'b0, 5'd2, 32'hDEAD, 5'd3, 32'hBEEF, 5'd8, 32'd0, 32'h99);
        wb_fwd_en = 1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'h1234;
        tick();
        clear_fwd();
        tick();
        $display("txn stall refresh");
        chk("stall_op2", operand2, 32'h1234);
        chk("stall_op1", operand1, 32'd1);
        chk("stall_rd", {27'd0, ex_rd_addr}, 32'd4);
        stall = 0;
        instr(7'b0010011, 3'b110, 1'b0, 5'd6, 32'hF0, 5'd0, 32'd0, 5'd10, 32'h0F, 32'h64);
        tick();
        $display("txn stall release ORI");
        chk("rel_alu_op", {28'd0, alu_op}, 32'h6);
        chk("rel_op1", operand1, 32'hF0);
        chk("rel_op2", operand2, 32'h0F);

        flush = 1; stall = 1;
        instr(7'b0110011, 3'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 32'h70);
        tick();
        flush = 0; stall = 0;
        $display("txn flush+stall");
        chk_bubble("flush");

        instr(7'b0110111, 3'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 32'h12345000, 32'h74);
        tick();
        $display("txn LUI");
        chk("lui_op1", operand1, 32'd0);
        chk("lui_op2", operand2, 32'h12345000);
        chk("lui_alu_op", {28'd0, alu_op}, 32'h0);
        rst = 1;
        tick();
        rst = 0;
        $display("txn reset pulse");
        chk_bubble("rst_pulse");

        instr(7'b1101111, 3'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h800, 32'h100);
        tick();
        $display("txn JAL rd1");
        chk("jal_op1", operand1, 32'h100);
        chk("jal_op2", operand2, 32'd4);
        chk("jal_rw", {31'd0, ex_reg_write}, 32'd1);
        in_rd_addr = 5'd0;
        tick();
        $display("txn JAL rd0");
        chk("jal0_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("jal0_op1", operand1, 32'h100);

        stall = 1;
        in_opcode = 7'b1100011; in_rd_addr = 5'd1;
        tick();
        rst = 1;
        tick();
        rst = 0; stall = 0; in_valid = 0;
        $display("txn reset mid-stall");
        chk_bubble("rst_stall");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute that feeds the ALU. Each accepted instruction is decoded into a 4-bit ALU operation code and operand-source selects, then registered. The stage drives `alu_op`, `operand1` and `operand2` to the ALU, applying MEM/WB bypassing to register operands in the same cycle. It supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold all registered state this cycle.
- `flush`  in  1: load a bubble this cycle; overrides `stall`.
- `in_valid`  in  1: decode presents a valid instruction.
- `in_pc`, `in_rs1_data`, `in_rs2_data`, `in_imm`  in  32 each: PC, register-file read data, sign-extended immediate.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each: source and destination register numbers.
- `in_opcode`  in  7; `in_funct3`  in  3; `in_funct7_5`  in  1: instruction bits [6:0], [14:12], [30].
- `mem_fwd_en`  in  1; `mem_fwd_rd`  in  5; `mem_fwd_data`  in  32: EX/MEM result bypass.
- `wb_fwd_en`  in  1; `wb_fwd_rd`  in  5; `wb_fwd_data`  in  32: writeback bypass. This is the same cycle as the register-file write.
- `ex_valid`  out  1: the registered slot holds a real instruction.
- `alu_op`  out  4: ALU code. ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- `operand1`, `operand2`  out  32: ALU operands after source select and bypass.
- `ex_rd_addr`  out  5; `ex_reg_write`  out  1; `ex_pc`  out  32: registered destination, write-enable and PC.

## Operation
- Decode is performed on the inputs and the results are registered. The decoded fields are `alu_op`, op1 select (RS1/PC/ZERO), op2 select (RS2/IMM/FOUR) and `reg_write`.
- Opcode `0110011` (OP): `alu_op={funct7_5,funct3}`; op1=RS1, op2=RS2; reg_write=1.
- Opcode `0010011` (OP-IMM): `alu_op={funct3==101 ? funct7_5 : 0, funct3}`; op1=RS1, op2=IMM; reg_write=1.
- Opcode `0110111` (LUI): ADD, ZERO, IMM, reg_write=1.
- Opcode `0010111` (AUIPC): ADD, PC, IMM, reg_write=1.
- Opcode `0000011` (LOAD): ADD, RS1, IMM, reg_write=1.
- Opcode `0100011` (STORE): ADD, RS1, IMM, reg_write=0.
- Opcodes `1101111`/`1100111` (JAL/JALR): ADD, PC, FOUR (link value), reg_write=1.
- Opcode `1100011` (BRANCH): SUB, RS1, RS2, reg_write=0.
- Any other opcode: ADD, RS1, RS2, reg_write=0.
- `ex_reg_write` is forced to 0 whenever `in_rd_addr`=0.
- Register update priority, highest first:
  - `rst`: all state 0.
  - `flush`: load a bubble (valid=0, reg_write=0, all other fields 0).
  - `stall`: hold.
  - `in_valid`=1: load the instruction.
  - Otherwise: load a bubble.
- WB refresh during hold: when `stall`=1 and `flush`=0, each held rs data register is overwritten with `wb_fwd_data` if `wb_fwd_en`=1, `wb_fwd_rd`≠0 and `wb_fwd_rd` equals the held rs address. This keeps the operand correct after the producing writeback retires.
- Bypass is combinational on the registered rs data and applies only when the select is RS1/RS2:
  - MEM match wins over WB match.
  - A match requires `*_fwd_en`=1, `*_fwd_rd`≠0 and equal address.
  - With no match, the registered data is used.
- Operand select values: PC uses `ex_pc`, ZERO is 0, FOUR is 32'd4, IMM is the registered immediate.
- A bubble drives `alu_op`=0000, operands 0 and `ex_reg_write`=0.

## Timing
- Latency is 1 cycle from input to registered outputs. Bypass has zero latency: a change on `mem_fwd_*`/`wb_fwd_*` is visible on the operands in the same cycle.
- Reset values: `ex_valid`=0, `alu_op`=0000, `operand1`=`operand2`=0, `ex_rd_addr`=0, `ex_reg_write`=0, `ex_pc`=0. Bypass is suppressed while in the reset state because selects reset to ZERO/FOUR-free zero data; operands must read 0.
- `rst` asserted mid-stall or mid-flush takes effect at the next edge, with no residue.
- `flush` and `stall` asserted together: a bubble is loaded.
- Inputs are sampled only on edges where `stall`=0. During a stall, input values are ignored except for `wb_fwd_*` (refresh).

## Test plan
- OP ADD with rs1 data 5, rs2 data 7, rd=3 -> next cycle `alu_op`=0000, `operand1`=5, `operand2`=7, `ex_reg_write`=1, `ex_rd_addr`=3.
- OP-IMM funct3=101, f7_5=1, imm=4 -> `alu_op`=1101, `operand2`=4. OP-IMM funct3=000, f7_5=1 -> `alu_op`=0000. OP funct3=000, f7_5=1 -> `alu_op`=1000.
- Bypass: held rs1_addr=5 with MEM rd=5 data 0xAAAA and WB rd=5 data 0xBBBB -> `operand1`=0xAAAA. Remove MEM -> 0xBBBB. MEM rd=0 with held rs=0 -> registered value.
- Stall 2 cycles while WB writes rs2 with 0x1234 in cycle 1 -> `operand2`=0x1234 in cycle 2 with no WB active. Release -> next instruction loads.
- `flush`=`stall`=1 with a valid ADD -> bubble next cycle (`ex_valid`=0, operands 0).
- LUI imm 0x12345000 -> `operand1`=0, `operand2`=0x12345000, ADD. Then `rst` pulse -> all outputs 0 at the next edge.
- JAL at pc 0x100, rd=1 -> `operand1`=0x100, `operand2`=4. Same instruction with rd=0 -> `ex_reg_write`=0.
